// File: rtl/toy_regfile_sb.sv
// Multi-read-port register file for the RISC_TOY pipeline, with a per-register
// outstanding-write scoreboard. Optional write-to-read bypass: TOY_RF_BYPASS_EN.
module toy_regfile_sb #(
    parameter int unsigned AW    = 5,
    parameter int unsigned ENTRY = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned NRP   = 2,
    parameter int unsigned CW    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NRP-1:0]    RE,
    input  logic [NRP*AW-1:0] RA,
    output logic [NRP*DW-1:0] DOUT,
    output logic [NRP-1:0]    HAZ,
    output logic              STALL,
    input  logic              WEN,
    input  logic [AW-1:0]     WA,
    input  logic [DW-1:0]     DI,
    input  logic              WB_RET,
    input  logic              ISS_VLD,
    input  logic [AW-1:0]     ISS_RD,
    output logic              ISS_RDY,
    input  logic              FLUSH,
    output logic [ENTRY-1:0]  BUSY_VEC,
    output logic              SB_ERR
);

    localparam logic [CW-1:0] CntMax = '1;
    localparam logic [CW-1:0] CntOne = CW'(1);

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < ENTRY;
    endfunction

    logic [DW-1:0] data_arr [ENTRY];
    logic [CW-1:0] cnt_arr  [ENTRY];

    logic          wa_ok;
    logic          iss_ok;
    logic [CW-1:0] cnt_wa;
    logic [CW-1:0] cnt_iss;
    logic          iss_acc;
    logic          retire;
    logic          ret_dec;
    logic          ret_err;
    logic          sb_err_q;
    logic          sb_err_d;

    assign wa_ok   = in_range(WA);
    assign iss_ok  = in_range(ISS_RD);
    assign cnt_wa  = wa_ok ? cnt_arr[WA] : '0;
    assign cnt_iss = iss_ok ? cnt_arr[ISS_RD] : '0;

    assign ISS_RDY = ISS_VLD & (cnt_iss != CntMax);
    assign iss_acc = ISS_RDY & iss_ok;

    // Retires in a flush cycle are dropped entirely, including the error check.
    assign retire  = WEN & WB_RET & wa_ok & ~FLUSH;
    assign ret_dec = retire & (cnt_wa != '0);
    assign ret_err = retire & (cnt_wa == '0);

    always_comb begin
        sb_err_d = sb_err_q | ret_err;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    assign SB_ERR = sb_err_q;

    for (genvar r = 0; r < ENTRY; r++) begin : g_reg
        logic [DW-1:0] data_q;
        logic [DW-1:0] data_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          inc;
        logic          dec;

        assign inc = iss_acc && (ISS_RD == AW'(r));
        assign dec = ret_dec && (WA == AW'(r));

        always_comb begin
            data_d = data_q;
            if (WEN && (WA == AW'(r))) begin
                data_d = DI;
            end
        end

        // A simultaneous issue and retire on one register cancel out.
        always_comb begin
            cnt_d = cnt_q;
            if (FLUSH) begin
                cnt_d = inc ? CntOne : '0;
            end else if (inc && !dec) begin
                cnt_d = cnt_q + CntOne;
            end else if (dec && !inc) begin
                cnt_d = cnt_q - CntOne;
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                data_q <= '0;
                cnt_q  <= '0;
            end else begin
                data_q <= data_d;
                cnt_q  <= cnt_d;
            end
        end

        assign data_arr[r] = data_q;
        assign cnt_arr[r]  = cnt_q;
        assign BUSY_VEC[r] = (cnt_q != '0);
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ra_ok;
        logic [CW-1:0] cnt_ra;
        logic [DW-1:0] stored;

        assign ra     = RA[i*AW +: AW];
        assign ra_ok  = in_range(ra);
        assign cnt_ra = ra_ok ? cnt_arr[ra] : '0;
        assign stored = ra_ok ? data_arr[ra] : '0;

`ifdef TOY_RF_BYPASS_EN
        logic fwd;
        logic kill;

        assign fwd  = WEN & wa_ok & (WA == ra);
        // The last pending write is retiring now and its data is forwarded.
        assign kill = fwd & WB_RET & (cnt_ra == CntOne);

        assign DOUT[i*DW +: DW] = fwd ? DI : stored;
        assign HAZ[i]           = RE[i] & (cnt_ra != '0) & ~kill;
`else
        assign DOUT[i*DW +: DW] = stored;
        assign HAZ[i]           = RE[i] & (cnt_ra != '0);
`endif
    end

    assign STALL = |HAZ;

endmodule

// File: tb/tb_toy_regfile_sb.sv
// Directed bench for toy_regfile_sb: reads/writes, scoreboard, flush, error, reset.
module tb_toy_regfile_sb;

    logic        CLK;
    logic        RST;
    logic [1:0]  RE;
    logic [9:0]  RA;
    logic [63:0] DOUT;
    logic [1:0]  HAZ;
    logic        STALL;
    logic        WEN;
    logic [4:0]  WA;
    logic [31:0] DI;
    logic        WB_RET;
    logic        ISS_VLD;
    logic [4:0]  ISS_RD;
    logic        ISS_RDY;
    logic        FLUSH;
    logic [31:0] BUSY_VEC;
    logic        SB_ERR;

    int tests = 0;
    int fails = 0;

    toy_regfile_sb dut (
        .CLK     (CLK),
        .RST     (RST),
        .RE      (RE),
        .RA      (RA),
        .DOUT    (DOUT),
        .HAZ     (HAZ),
        .STALL   (STALL),
        .WEN     (WEN),
        .WA      (WA),
        .DI      (DI),
        .WB_RET  (WB_RET),
        .ISS_VLD (ISS_VLD),
        .ISS_RD  (ISS_RD),
        .ISS_RDY (ISS_RDY),
        .FLUSH   (FLUSH),
        .BUSY_VEC(BUSY_VEC),
        .SB_ERR  (SB_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WEN = 1'b0; WB_RET = 1'b0; ISS_VLD = 1'b0; FLUSH = 1'b0;
    endtask

    initial begin
        RST = 1'b1; RE = '0; RA = '0; WA = '0; DI = '0; ISS_RD = '0;
        idle();
        #2;
        check("rst_dout", DOUT, 64'h0);
        check("rst_haz", 64'(HAZ), 64'h0);
        check("rst_stall", 64'(STALL), 64'h0);
        check("rst_busy", 64'(BUSY_VEC), 64'h0);
        check("rst_sberr", 64'(SB_ERR), 64'h0);
        check("rst_rdy_idle", 64'(ISS_RDY), 64'h0);
        ISS_VLD = 1'b1;
        #1;
        check("rst_rdy_vld", 64'(ISS_RDY), 64'h1);
        ISS_VLD = 1'b0;
        #5;
        RST = 1'b0;

        // write r3 = A5, read r3 on port 0 and r4 on port 1
        WEN = 1'b1; WA = 5'd3; DI = 32'hA5; RA = {5'd4, 5'd3};
        #1;
`ifdef TOY_RF_BYPASS_EN
        check("wr_same_cycle", DOUT, 64'h0000_0000_0000_00A5);
`else
        check("wr_same_cycle", DOUT, 64'h0);
`endif
        tick();
        idle();
        #1;
        check("rd_r3_r4", DOUT, 64'h0000_0000_0000_00A5);

        // issue r7, hazard for three cycles, then retire with 0x1234
        ISS_VLD = 1'b1; ISS_RD = 5'd7; RA = {5'd4, 5'd7}; RE = 2'b01;
        #1;
        check("iss7_rdy", 64'(ISS_RDY), 64'h1);
        check("iss7_haz_pre", 64'(HAZ), 64'h0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("iss7_haz", 64'(HAZ), 64'h1);
            check("iss7_stall", 64'(STALL), 64'h1);
            tick();
        end
        WEN = 1'b1; WB_RET = 1'b1; WA = 5'd7; DI = 32'h1234;
        #1;
        check("ret7_busy", 64'(BUSY_VEC), 64'h80);
`ifdef TOY_RF_BYPASS_EN
        check("ret7_haz", 64'(HAZ), 64'h0);
        check("ret7_dout", 64'(DOUT[31:0]), 64'h1234);
`else
        check("ret7_haz", 64'(HAZ), 64'h1);
        check("ret7_dout", 64'(DOUT[31:0]), 64'h0);
`endif
        tick();
        idle();
        #1;
        check("post7_haz", 64'(HAZ), 64'h0);
        check("post7_stall", 64'(STALL), 64'h0);
        check("post7_dout", 64'(DOUT[31:0]), 64'h1234);
        check("post7_busy", 64'(BUSY_VEC), 64'h0);

        // saturate r5 at 3 pending writes
        ISS_VLD = 1'b1; ISS_RD = 5'd5; RA = {5'd4, 5'd5}; RE = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("iss5_rdy", 64'(ISS_RDY), 64'h1);
            tick();
        end
        #1;
        check("iss5_full", 64'(ISS_RDY), 64'h0);
        tick();
        idle();
        #1;
        check("iss5_busy", 64'(BUSY_VEC), 64'h20);
        WEN = 1'b1; WB_RET = 1'b1; WA = 5'd5;
        for (int k = 0; k < 3; k++) begin
            DI = 32'(k);
            #1;
            if (k == 2) check("ret5_two_left", 64'(BUSY_VEC), 64'h20);
            tick();
        end
        idle();
        #1;
        check("ret5_busy", 64'(BUSY_VEC), 64'h0);
        check("ret5_sberr", 64'(SB_ERR), 64'h0);
        check("ret5_dout", 64'(DOUT[31:0]), 64'h2);

        // issue and retire r9 in the same cycle with cnt = 1
        ISS_VLD = 1'b1; ISS_RD = 5'd9; RA = {5'd4, 5'd9}; RE = 2'b01;
        tick();
        WEN = 1'b1; WB_RET = 1'b1; WA = 5'd9; DI = 32'h99;
        #1;
        check("iss9_rdy", 64'(ISS_RDY), 64'h1);
        tick();
        idle();
        #1;
        check("r9_haz", 64'(HAZ), 64'h1);
        check("r9_busy", 64'(BUSY_VEC), 64'h200);
        WEN = 1'b1; WB_RET = 1'b1; WA = 5'd9;
        tick();
        idle();
        #1;
        check("r9_cleared", 64'(BUSY_VEC), 64'h0);
        check("r9_sberr", 64'(SB_ERR), 64'h0);

        // r2 x2, r6 x1, then flush with issue r6 and a dropped retire on r1
        RE = 2'b00;
        ISS_VLD = 1'b1; ISS_RD = 5'd2;
        tick();
        tick();
        ISS_RD = 5'd6;
        tick();
        idle();
        #1;
        check("pre_flush_busy", 64'(BUSY_VEC), 64'h44);
        FLUSH = 1'b1; ISS_VLD = 1'b1; ISS_RD = 5'd6;
        WEN = 1'b1; WB_RET = 1'b1; WA = 5'd1; DI = 32'h0;
        tick();
        idle();
        RA = {5'd7, 5'd3};
        #1;
        check("flush_busy", 64'(BUSY_VEC), 64'h40);
        check("flush_sberr", 64'(SB_ERR), 64'h0);
        check("flush_regs", DOUT, 64'h0000_1234_0000_00A5);
        WEN = 1'b1; WB_RET = 1'b1; WA = 5'd6; DI = 32'h66;
        tick();
        idle();
        #1;
        check("r6_cleared", 64'(BUSY_VEC), 64'h0);

        // retire against an empty counter sets the sticky error
        WEN = 1'b1; WB_RET = 1'b1; WA = 5'd1; DI = 32'h55;
        tick();
        idle();
        RA = {5'd4, 5'd1};
        #1;
        check("sberr_set", 64'(SB_ERR), 64'h1);
        check("sberr_wr", 64'(DOUT[31:0]), 64'h55);
        repeat (3) tick();
        check("sberr_hold", 64'(SB_ERR), 64'h1);

        // mid-cycle reset clears everything, and the write held across it is lost
        ISS_VLD = 1'b1; ISS_RD = 5'd10;
        tick();
        idle();
        RE = 2'b01; RA = {5'd3, 5'd10};
        #1;
        check("r10_busy", 64'(BUSY_VEC), 64'h400);
        check("r10_haz", 64'(HAZ), 64'h1);
        WEN = 1'b1; WA = 5'd12; DI = 32'hFF;
        RST = 1'b1;
        #1;
        check("arst_sberr", 64'(SB_ERR), 64'h0);
        check("arst_busy", 64'(BUSY_VEC), 64'h0);
        check("arst_haz", 64'(HAZ), 64'h0);
        check("arst_stall", 64'(STALL), 64'h0);
        check("arst_dout", DOUT, 64'h0);
        tick();
        RST = 1'b0;
        idle();
        RA = {5'd12, 5'd3};
        #1;
        check("arst_lost_wr", DOUT, 64'h0);
        check("arst_sberr_after", 64'(SB_ERR), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/toy_regfile_sb.md
# toy_regfile_sb

Parametrised multi-read-port general-purpose register file with an integrated per-register write scoreboard. It is the next-generation register file for the RISC_TOY pipeline. The decode stage reads operands through NRP combinational ports and gets a per-port hazard flag. Issue marks a destination register as pending, and writeback retires it. Optional same-cycle write-to-read bypass removes one stall cycle on back-to-back dependencies.

## Interface
Parameters:
- AW, 5, register address width
- ENTRY, 32, number of registers (≤ 2^AW)
- DW, 32, data width
- NRP, 2, number of read ports
- CW, 2, per-register outstanding-write counter width (max 2^CW−1 pending)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous, active-high
- RE  in  NRP  read enable per port (only gates HAZ)
- RA  in  NRP*AW  read addresses, port i at [i*AW +: AW]
- DOUT  out  NRP*DW  read data, port i at [i*DW +: DW]
- HAZ  out  NRP  per-port hazard: read register has pending write
- STALL  out  1  OR of HAZ
- WEN  in  1  write enable
- WA  in  AW  write address
- DI  in  DW  write data
- WB_RET  in  1  this write retires one scoreboard entry of WA (valid only with WEN)
- ISS_VLD  in  1  issue request: mark ISS_RD pending
- ISS_RD  in  AW  issued destination register
- ISS_RDY  out  1  issue accepted this cycle
- FLUSH  in  1  clear all scoreboard counters
- BUSY_VEC  out  ENTRY  bit r = counter[r] ≠ 0 (registered)
- SB_ERR  out  1  sticky: retire against zero counter

## Operation
- Storage: ENTRY×DW flops. On WEN at the clock edge, reg[WA] ← DI. Addresses ≥ ENTRY are ignored for writes and read as 0.
- Reads: DOUT is combinational from reg[RA] (see Configuration for bypass). No register is hardwired to zero.
- Scoreboard: counter cnt[r] of CW bits per register.
  - Issue accept: ISS_RDY = ISS_VLD & (cnt[ISS_RD] ≠ 2^CW−1), combinational.
  - Increment: accepted issue → cnt[ISS_RD] +1.
  - Retire: WEN & WB_RET with cnt[WA] ≠ 0 → cnt[WA] −1.
  - Retire with cnt[WA] = 0 → counter unchanged, SB_ERR ← 1 (held until RST).
  - Accepted issue and retire on the same register in the same cycle → counter unchanged.
  - FLUSH → all counters 0, then any accepted same-cycle issue applies, so cnt[ISS_RD] = 1. Retires in a FLUSH cycle are dropped and do not set SB_ERR. FLUSH does not alter register contents.
- Hazard: HAZ[i] = RE[i] & (cnt[RA_i] ≠ 0), evaluated against the registered counter. Bypass adjustment is in Configuration.
- Counters never wrap; saturation is prevented by ISS_RDY.

## Timing
- Reset values: all registers 0, all counters 0, BUSY_VEC 0, SB_ERR 0, HAZ 0, STALL 0, DOUT 0, ISS_RDY = ISS_VLD & 1.
- Read latency 0 cycles (combinational). Write visible on DOUT the cycle after the WEN edge (or same cycle with bypass).
- Issue takes effect at the edge. HAZ for that register asserts the next cycle.
- Retire takes effect at the edge. Without bypass, HAZ clears the next cycle.
- RST mid-operation clears all state immediately and asynchronously. An in-flight write at the RST edge is lost.

## Configuration
- TOY_RF_BYPASS_EN defined:
  - When WEN and WA = RA_i, DOUT_i = DI.
  - HAZ[i] is suppressed if WEN & WB_RET & WA = RA_i & cnt[RA_i] = 1, because the retiring value is forwarded in the same cycle.
- Undefined:
  - DOUT always returns stored reg contents.
  - HAZ uses only the registered counter, so the dependent read stalls one extra cycle.

## Test plan
- Reset, then write r3 = 0x0000_00A5 → next cycle, reading port 0 at r3 gives 0x0000_00A5; port 1 at r4 gives 0.
- Issue r7, 3 cycles later WEN+WB_RET r7 = 0x1234 → HAZ[0] on r7 is high for 3 cycles. With bypass, the retire cycle shows DOUT = 0x1234 and HAZ low; without bypass, HAZ drops one cycle later.
- With CW = 2, issue r5 three times → ISS_RDY low on the 4th request, cnt stays 3; three retires clear BUSY_VEC[5].
- Same cycle: issue r9 and retire r9 with cnt = 1 → cnt stays 1, HAZ on r9 remains high.
- Set cnt r2 = 2 and r6 = 1, then FLUSH together with issue r6 → BUSY_VEC = only bit 6, registers unchanged, SB_ERR 0.
- Retire r1 with cnt = 0 → SB_ERR = 1 and stays 1 until RST; raising RST mid-sequence clears everything within the same cycle.
